tlb_mmu: RTL and testbench
==========================

TLB_MMU -- requirements
Module: tlb_mmu

Interface
REQ-001 SHALL have parameter TLBNUM, default 16, meaning entry count; index width is log2(TLBNUM)=4.
REQ-002 SHALL have clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have rst  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have cp0_index  in  4  target entry for TLBWI/TLBR (Index[3:0]).
REQ-005 SHALL have cp0_entryhi  in  27  {vpn2[26:8], asid[7:0]} from EntryHi.
REQ-006 SHALL have cp0_lo0 and cp0_lo1  in  26 each  {pfn[25:6], c[5:3], d, v, g} from EntryLo0/1.
REQ-007 SHALL have tlbwi_req, tlbp_req, tlbr_req  in  1 each  single-cycle command pulses.
REQ-008 SHALL have probe_done  out  1, probe_found  out  1, probe_index  out  4  TLBP result to Index.
REQ-009 SHALL have rd_done  out  1, rd_entryhi  out  27, rd_lo0 and rd_lo1  out  26 each  TLBR result.
REQ-010 SHALL have lk_req  in  1, lk_vaddr  in  32, lk_store  in  1  data translation request.
REQ-011 SHALL have lk_done  out  1, lk_paddr  out  32, lk_refill  out  1, lk_invalid  out  1, lk_modified  out  1  translation result.

Function
REQ-012 Entry storage SHALL hold vpn2, asid, G, and {pfn,c,d,v} per odd/even page; G = g0 AND g1 at write.
REQ-013 tlbwi_req SHALL write entry cp0_index from cp0 inputs at the edge it is sampled; visible to any operation issued the next cycle.
REQ-014 tlbp_req SHALL set probe_done for exactly 1 cycle, 1 cycle after the request, with registered probe_found/probe_index.
REQ-015 Match rule: entry.vpn2 == key vpn2 AND (entry.G OR entry.asid == key asid); TLBP key = cp0_entryhi.
REQ-016 Multiple matches SHALL resolve to lowest index; no match SHALL give probe_found=0, probe_index=0.
REQ-017 tlbr_req SHALL pulse rd_done 1 cycle later with entry cp0_index contents; rd_lo0.g = rd_lo1.g = entry G.
REQ-018 Commands are mutually exclusive by contract; if several are asserted, priority SHALL be tlbwi > tlbp > tlbr and the losers dropped.
REQ-019 TLBP/TLBR issued in the same cycle as a TLBWI (lower priority, dropped) SHALL produce no done pulse.
REQ-020 Lookup latency SHALL be 1 cycle: lk_done pulses the cycle after lk_req, and back-to-back requests every cycle SHALL be supported.
REQ-021 Lookup key = {lk_vaddr[31:13], cp0_entryhi asid}; page select = lk_vaddr[12] (0 even, 1 odd).
REQ-022 lk_vaddr[31:30]==2'b10 (kseg0/kseg1) SHALL bypass TLB: lk_paddr = {3'b000, vaddr[28:0]}, all fault flags 0.
REQ-023 Mapped miss SHALL set lk_refill=1; hit with v=0 SHALL set lk_invalid=1; hit, v=1, d=0, lk_store=1 SHALL set lk_modified=1.
REQ-024 Flags are mutually exclusive; on hit lk_paddr = {pfn[19:0], vaddr[11:0]} even when a fault flag is set.
REQ-025 Lookup issued in the same cycle as a TLBWI SHALL translate against the pre-write contents.
REQ-026 Done outputs SHALL be 0 in any cycle without a corresponding request on the previous edge; data outputs hold last values.

Reset
REQ-027 On rst low, all entries SHALL clear to zero (v0=v1=G=0) asynchronously.
REQ-028 On rst low, all outputs SHALL be 0; an in-flight lookup/probe/read SHALL be discarded with no done pulse after release.

Verification
REQ-029 Reset, then TLBP with entryhi vpn2=0x00001, asid=0x05 -> probe_done 1 cycle later, probe_found=0, probe_index=0.
REQ-030 TLBWI idx 3 (vpn2=0x00400, asid=0x05, lo0 pfn=0x00123 v=1 d=1, g=0) then lookup vaddr 0x00800ABC -> lk_paddr=0x00123ABC, flags 0.
REQ-031 Same entry, asid changed to 0x06, lookup 0x00800ABC -> lk_refill=1; rewrite with g0=g1=1 -> hit again.
REQ-032 Lookup 0x00801000 (odd page, lo1 v=0) -> lk_invalid=1; store to even page with d=0 -> lk_modified=1.
REQ-033 Identical vpn2 written at idx 2 and idx 9, TLBP -> probe_found=1, probe_index=2; TLBR idx 9 -> rd fields match written values.
REQ-034 Lookup 0xBFC00000 -> lk_paddr=0x1FC00000, no flags; lookup and TLBWI same cycle -> old-content result, new result next request.

Source files
------------

// File: rtl/tlb_mmu.sv
// -----------------------------------------------------------------------------
// tlb_mmu
// Fully associative MIPS-style joint TLB with CP0 maintenance commands
// (TLBWI / TLBP / TLBR) and a single-cycle data address translation port.
// Each entry maps an even/odd page pair selected by vaddr[12].
//
// Ports
//   clk, rst                      clock; asynchronous active-low reset
//   cp0_index                     entry targeted by TLBWI / TLBR
//   cp0_entryhi                   {vpn2[18:0], asid[7:0]}; TLBP key, write data,
//                                 and the ASID used by translation lookups
//   cp0_lo0, cp0_lo1              {pfn[19:0], c[2:0], d, v, g} per page
//   tlbwi_req/tlbp_req/tlbr_req   command pulses (priority wi > p > r)
//   probe_done/found/index        TLBP result, one cycle after the request
//   rd_done/entryhi/lo0/lo1       TLBR result, one cycle after the request
//   lk_req/lk_vaddr/lk_store      translation request
//   lk_done/paddr/refill/invalid/modified  translation result, one cycle later
// -----------------------------------------------------------------------------
module tlb_mmu #(
    parameter int TLBNUM = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [$clog2(TLBNUM)-1:0] cp0_index,
    input  logic [26:0]               cp0_entryhi,
    input  logic [25:0]               cp0_lo0,
    input  logic [25:0]               cp0_lo1,
    input  logic                      tlbwi_req,
    input  logic                      tlbp_req,
    input  logic                      tlbr_req,
    output logic                      probe_done,
    output logic                      probe_found,
    output logic [$clog2(TLBNUM)-1:0] probe_index,
    output logic                      rd_done,
    output logic [26:0]               rd_entryhi,
    output logic [25:0]               rd_lo0,
    output logic [25:0]               rd_lo1,
    input  logic                      lk_req,
    input  logic [31:0]               lk_vaddr,
    input  logic                      lk_store,
    output logic                      lk_done,
    output logic [31:0]               lk_paddr,
    output logic                      lk_refill,
    output logic                      lk_invalid,
    output logic                      lk_modified
);

    localparam int IW = $clog2(TLBNUM);

    // Per-page payload is {pfn[19:0], c[2:0], d, v}; the global bit is kept
    // once per entry as the AND of both pages' g bits.
    logic [18:0] e_vpn2 [TLBNUM];
    logic [7:0]  e_asid [TLBNUM];
    logic        e_g    [TLBNUM];
    logic [24:0] e_p0   [TLBNUM];
    logic [24:0] e_p1   [TLBNUM];

    logic          pr_hit;
    logic [IW-1:0] pr_idx;
    logic          lk_hit;
    logic [IW-1:0] lk_idx;
    logic [24:0]   lk_pg;
    logic          bypass;
    logic          probe_go;
    logic          read_go;

    // Entry storage; a write lands at the edge so lookups in the same cycle
    // still see the old contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TLBNUM; i++) begin
                e_vpn2[i] <= '0;
                e_asid[i] <= '0;
                e_g[i]    <= 1'b0;
                e_p0[i]   <= '0;
                e_p1[i]   <= '0;
            end
        end else if (tlbwi_req) begin
            e_vpn2[cp0_index] <= cp0_entryhi[26:8];
            e_asid[cp0_index] <= cp0_entryhi[7:0];
            e_g[cp0_index]    <= cp0_lo0[0] & cp0_lo1[0];
            e_p0[cp0_index]   <= cp0_lo0[25:1];
            e_p1[cp0_index]   <= cp0_lo1[25:1];
        end
    end

    // Two parallel CAM searches sharing the CP0 ASID. Scanning from the top
    // down lets the lowest matching index win.
    always_comb begin
        pr_hit = 1'b0;
        pr_idx = '0;
        lk_hit = 1'b0;
        lk_idx = '0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (e_g[i] || (e_asid[i] == cp0_entryhi[7:0])) begin
                if (e_vpn2[i] == cp0_entryhi[26:8]) begin
                    pr_hit = 1'b1;
                    pr_idx = IW'(i);
                end
                if (e_vpn2[i] == lk_vaddr[31:13]) begin
                    lk_hit = 1'b1;
                    lk_idx = IW'(i);
                end
            end
        end
    end

    assign lk_pg    = lk_vaddr[12] ? e_p1[lk_idx] : e_p0[lk_idx];
    assign bypass   = (lk_vaddr[31:30] == 2'b10);
    assign probe_go = tlbp_req & ~tlbwi_req;
    assign read_go  = tlbr_req & ~tlbwi_req & ~tlbp_req;

    // Result registers: done strobes follow the request by one cycle,
    // data fields only change when a winning request supplies new values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            probe_done  <= 1'b0;
            probe_found <= 1'b0;
            probe_index <= '0;
            rd_done     <= 1'b0;
            rd_entryhi  <= '0;
            rd_lo0      <= '0;
            rd_lo1      <= '0;
            lk_done     <= 1'b0;
            lk_paddr    <= '0;
            lk_refill   <= 1'b0;
            lk_invalid  <= 1'b0;
            lk_modified <= 1'b0;
        end else begin
            probe_done <= probe_go;
            rd_done    <= read_go;
            lk_done    <= lk_req;
            if (probe_go) begin
                probe_found <= pr_hit;
                probe_index <= pr_idx;
            end
            if (read_go) begin
                rd_entryhi <= {e_vpn2[cp0_index], e_asid[cp0_index]};
                rd_lo0     <= {e_p0[cp0_index], e_g[cp0_index]};
                rd_lo1     <= {e_p1[cp0_index], e_g[cp0_index]};
            end
            if (lk_req) begin
                lk_refill   <= 1'b0;
                lk_invalid  <= 1'b0;
                lk_modified <= 1'b0;
                if (bypass) begin
                    lk_paddr <= {3'b000, lk_vaddr[28:0]};
                end else if (!lk_hit) begin
                    lk_paddr  <= '0;
                    lk_refill <= 1'b1;
                end else begin
                    // Physical address is produced even when a fault is flagged.
                    lk_paddr <= {lk_pg[24:5], lk_vaddr[11:0]};
                    if (!lk_pg[0]) begin
                        lk_invalid <= 1'b1;
                    end else if (lk_store && !lk_pg[1]) begin
                        lk_modified <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tlb_mmu.sv
// -----------------------------------------------------------------------------
// tb_tlb_mmu
// Self-checking bench for tlb_mmu. A behavioural TLB model (raw CP0 words per
// entry, linear lowest-index search) predicts every probe, read and lookup.
// -----------------------------------------------------------------------------
module tb_tlb_mmu;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  cp0_index;
    logic [26:0] cp0_entryhi;
    logic [25:0] cp0_lo0, cp0_lo1;
    logic        tlbwi_req, tlbp_req, tlbr_req;
    logic        probe_done, probe_found;
    logic [3:0]  probe_index;
    logic        rd_done;
    logic [26:0] rd_entryhi;
    logic [25:0] rd_lo0, rd_lo1;
    logic        lk_req, lk_store;
    logic [31:0] lk_vaddr;
    logic        lk_done;
    logic [31:0] lk_paddr;
    logic        lk_refill, lk_invalid, lk_modified;

    int checks   = 0;
    int failures = 0;

    logic [26:0] m_hi  [16];
    logic [25:0] m_lo0 [16];
    logic [25:0] m_lo1 [16];

    tlb_mmu #(.TLBNUM(16)) dut (
        .clk(clk), .rst(rst),
        .cp0_index(cp0_index), .cp0_entryhi(cp0_entryhi),
        .cp0_lo0(cp0_lo0), .cp0_lo1(cp0_lo1),
        .tlbwi_req(tlbwi_req), .tlbp_req(tlbp_req), .tlbr_req(tlbr_req),
        .probe_done(probe_done), .probe_found(probe_found), .probe_index(probe_index),
        .rd_done(rd_done), .rd_entryhi(rd_entryhi), .rd_lo0(rd_lo0), .rd_lo1(rd_lo1),
        .lk_req(lk_req), .lk_vaddr(lk_vaddr), .lk_store(lk_store),
        .lk_done(lk_done), .lk_paddr(lk_paddr), .lk_refill(lk_refill),
        .lk_invalid(lk_invalid), .lk_modified(lk_modified)
    );

    always #5 clk = ~clk;

    function automatic logic [25:0] mk_lo(input logic [19:0] pfn, input logic d,
                                          input logic v, input logic g);
        return {pfn, 3'b011, d, v, g};
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < 16; k++) begin
            m_hi[k] = '0; m_lo0[k] = '0; m_lo1[k] = '0;
        end
    endfunction

    function automatic int model_match(input logic [18:0] vpn2, input logic [7:0] asid);
        for (int k = 0; k < 16; k++)
            if (m_hi[k][26:8] == vpn2 && ((m_lo0[k][0] && m_lo1[k][0]) || m_hi[k][7:0] == asid))
                return k;
        return -1;
    endfunction

    function automatic void model_lookup(input logic [31:0] va, input logic st,
                                         input logic [7:0] asid, output logic [31:0] pa,
                                         output logic r, output logic iv, output logic md);
        int hit;
        logic [25:0] lo;
        pa = '0; r = 1'b0; iv = 1'b0; md = 1'b0;
        if (va[31:30] == 2'b10) begin
            pa = {3'b000, va[28:0]};
            return;
        end
        hit = model_match(va[31:13], asid);
        if (hit < 0) begin
            r = 1'b1;
            return;
        end
        lo = va[12] ? m_lo1[hit] : m_lo0[hit];
        pa = {lo[25:6], va[11:0]};
        if (!lo[1]) iv = 1'b1;
        else if (st && !lo[2]) md = 1'b1;
    endfunction

    task automatic idle_inputs();
        tlbwi_req = 0; tlbp_req = 0; tlbr_req = 0; lk_req = 0; lk_store = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input logic [3:0] idx, input logic [26:0] hi,
                               input logic [25:0] lo0, input logic [25:0] lo1);
        cp0_index = idx; cp0_entryhi = hi; cp0_lo0 = lo0; cp0_lo1 = lo1;
        tlbwi_req = 1;
        step();
        tlbwi_req = 0;
        m_hi[idx] = hi; m_lo0[idx] = lo0; m_lo1[idx] = lo1;
    endtask

    task automatic lookup(input logic [31:0] va, input logic st);
        lk_req = 1; lk_vaddr = va; lk_store = st;
        step();
        lk_req = 0; lk_store = 0;
    endtask

    task automatic test_reset();
        rst = 0;
        idle_inputs();
        cp0_index = 0; cp0_entryhi = 0; cp0_lo0 = 0; cp0_lo1 = 0; lk_vaddr = 0;
        model_clear();
        step(); step();
        checks++;
        if ({probe_done, probe_found, probe_index, rd_done, rd_entryhi, rd_lo0, rd_lo1,
             lk_done, lk_paddr, lk_refill, lk_invalid, lk_modified} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got pd=%b rd=%b lk=%b pa=%h, want all zero",
                     probe_done, rd_done, lk_done, lk_paddr);
        end
        rst = 1;
        step();
        cp0_entryhi = {19'h00001, 8'h05};
        tlbp_req = 1;
        step();
        tlbp_req = 0;
        checks++;
        if ({probe_done, probe_found, probe_index} !== {1'b1, 1'b0, 4'd0}) begin
            failures++;
            $display("[TB] FAIL probe_empty: got done=%b found=%b idx=%0d, want 1/0/0",
                     probe_done, probe_found, probe_index);
        end
        step();
        checks++;
        if (probe_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL probe_single_pulse: got done=%b, want 0", probe_done);
        end
    endtask

    task automatic test_translate();
        logic [31:0] ep; logic er, ei, em;
        write_entry(4'd3, {19'h00400, 8'h05}, mk_lo(20'h00123, 1, 1, 0), mk_lo(20'h00456, 0, 0, 0));
        cp0_entryhi = {19'h00400, 8'h05};
        model_lookup(32'h00800ABC, 0, 8'h05, ep, er, ei, em);
        lookup(32'h00800ABC, 0);
        checks++;
        if (lk_done !== 1 || lk_paddr !== 32'h00123ABC || {lk_refill, lk_invalid, lk_modified} !== 3'b000
            || ep !== 32'h00123ABC) begin
            failures++;
            $display("[TB] FAIL lookup_hit: got done=%b pa=%h flags=%b%b%b, want 1 00123abc 000",
                     lk_done, lk_paddr, lk_refill, lk_invalid, lk_modified);
        end
        step();
        checks++;
        if (lk_done !== 0 || lk_paddr !== 32'h00123ABC) begin
            failures++;
            $display("[TB] FAIL lookup_hold: got done=%b pa=%h, want 0 00123abc", lk_done, lk_paddr);
        end
        cp0_entryhi = {19'h00400, 8'h06};
        lookup(32'h00800ABC, 0);
        checks++;
        if (lk_done !== 1 || {lk_refill, lk_invalid, lk_modified} !== 3'b100) begin
            failures++;
            $display("[TB] FAIL asid_miss: got done=%b flags=%b%b%b, want 1 100",
                     lk_done, lk_refill, lk_invalid, lk_modified);
        end
        write_entry(4'd3, {19'h00400, 8'h05}, mk_lo(20'h00123, 1, 1, 1), mk_lo(20'h00456, 0, 0, 1));
        cp0_entryhi = {19'h00400, 8'h06};
        lookup(32'h00800ABC, 0);
        checks++;
        if (lk_done !== 1 || lk_paddr !== 32'h00123ABC || {lk_refill, lk_invalid, lk_modified} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL global_hit: got done=%b pa=%h flags=%b%b%b, want 1 00123abc 000",
                     lk_done, lk_paddr, lk_refill, lk_invalid, lk_modified);
        end
        lookup(32'h00801000, 0);
        checks++;
        if (lk_done !== 1 || lk_paddr !== 32'h00456000 || {lk_refill, lk_invalid, lk_modified} !== 3'b010) begin
            failures++;
            $display("[TB] FAIL odd_invalid: got done=%b pa=%h flags=%b%b%b, want 1 00456000 010",
                     lk_done, lk_paddr, lk_refill, lk_invalid, lk_modified);
        end
        write_entry(4'd3, {19'h00400, 8'h05}, mk_lo(20'h00123, 0, 1, 1), mk_lo(20'h00456, 0, 0, 1));
        lookup(32'h00800ABC, 1);
        checks++;
        if (lk_done !== 1 || lk_paddr !== 32'h00123ABC || {lk_refill, lk_invalid, lk_modified} !== 3'b001) begin
            failures++;
            $display("[TB] FAIL store_modified: got done=%b pa=%h flags=%b%b%b, want 1 00123abc 001",
                     lk_done, lk_paddr, lk_refill, lk_invalid, lk_modified);
        end
        lookup(32'h00800ABC, 0);
        checks++;
        if ({lk_refill, lk_invalid, lk_modified} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL load_clean_page: got flags=%b%b%b, want 000",
                     lk_refill, lk_invalid, lk_modified);
        end
    endtask

    task automatic test_probe_read();
        logic [26:0] hi;
        hi = {19'h12345, 8'h07};
        write_entry(4'd9, hi, mk_lo(20'hAAAAA, 1, 1, 1), mk_lo(20'hBBBBB, 0, 1, 0));
        write_entry(4'd2, hi, mk_lo(20'hCCCCC, 1, 1, 0), mk_lo(20'hDDDDD, 1, 0, 0));
        cp0_entryhi = hi;
        tlbp_req = 1;
        step();
        tlbp_req = 0;
        checks++;
        if ({probe_done, probe_found, probe_index} !== {1'b1, 1'b1, 4'd2}) begin
            failures++;
            $display("[TB] FAIL probe_lowest: got done=%b found=%b idx=%0d, want 1/1/2",
                     probe_done, probe_found, probe_index);
        end
        cp0_index = 4'd9;
        tlbr_req = 1;
        step();
        tlbr_req = 0;
        checks++;
        if (rd_done !== 1 || rd_entryhi !== hi || rd_lo0 !== {20'hAAAAA, 3'b011, 1'b1, 1'b1, 1'b0}
            || rd_lo1 !== {20'hBBBBB, 3'b011, 1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("[TB] FAIL read_idx9: got done=%b hi=%h lo0=%h lo1=%h, want 1 %h %h %h",
                     rd_done, rd_entryhi, rd_lo0, rd_lo1, hi,
                     {20'hAAAAA, 3'b011, 1'b1, 1'b1, 1'b0}, {20'hBBBBB, 3'b011, 1'b0, 1'b1, 1'b0});
        end
        step();
        checks++;
        if (rd_done !== 0 || rd_entryhi !== hi) begin
            failures++;
            $display("[TB] FAIL read_single_pulse: got done=%b hi=%h, want 0 %h", rd_done, rd_entryhi, hi);
        end
    endtask

    task automatic test_priority();
        cp0_index = 4'd5;
        cp0_entryhi = {19'h0ABCD, 8'h11};
        cp0_lo0 = mk_lo(20'h11111, 1, 1, 0);
        cp0_lo1 = mk_lo(20'h22222, 1, 1, 0);
        tlbwi_req = 1; tlbp_req = 1; tlbr_req = 1;
        step();
        idle_inputs();
        m_hi[5] = cp0_entryhi; m_lo0[5] = cp0_lo0; m_lo1[5] = cp0_lo1;
        checks++;
        if (probe_done !== 0 || rd_done !== 0) begin
            failures++;
            $display("[TB] FAIL dropped_cmds: got probe_done=%b rd_done=%b, want 0 0", probe_done, rd_done);
        end
        tlbp_req = 1; tlbr_req = 1;
        step();
        idle_inputs();
        checks++;
        if ({probe_done, probe_found, probe_index, rd_done} !== {1'b1, 1'b1, 4'd5, 1'b0}) begin
            failures++;
            $display("[TB] FAIL probe_over_read: got pd=%b found=%b idx=%0d rd=%b, want 1 1 5 0",
                     probe_done, probe_found, probe_index, rd_done);
        end
    endtask

    task automatic test_bypass_same_cycle();
        logic [31:0] ep; logic er, ei, em;
        lookup(32'hBFC00000, 1);
        checks++;
        if (lk_done !== 1 || lk_paddr !== 32'h1FC00000 || {lk_refill, lk_invalid, lk_modified} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL kseg_bypass: got done=%b pa=%h flags=%b%b%b, want 1 1fc00000 000",
                     lk_done, lk_paddr, lk_refill, lk_invalid, lk_modified);
        end
        cp0_entryhi = {19'h00400, 8'h05};
        model_lookup(32'h00800ABC, 0, 8'h05, ep, er, ei, em);
        cp0_index = 4'd3;
        cp0_lo0 = mk_lo(20'h00ABC, 1, 1, 0);
        cp0_lo1 = mk_lo(20'h00DEF, 1, 1, 0);
        tlbwi_req = 1; lk_req = 1; lk_vaddr = 32'h00800ABC;
        step();
        idle_inputs();
        m_hi[3] = cp0_entryhi; m_lo0[3] = cp0_lo0; m_lo1[3] = cp0_lo1;
        checks++;
        if (lk_done !== 1 || lk_paddr !== ep || ep !== 32'h00123ABC) begin
            failures++;
            $display("[TB] FAIL write_same_cycle_old: got done=%b pa=%h, want 1 00123abc", lk_done, lk_paddr);
        end
        lookup(32'h00800ABC, 0);
        checks++;
        if (lk_done !== 1 || lk_paddr !== 32'h00ABCABC) begin
            failures++;
            $display("[TB] FAIL write_next_new: got done=%b pa=%h, want 1 00abcabc", lk_done, lk_paddr);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ep, last_pa; logic er, ei, em, req, last_known;
        logic [3:0] widx; logic wr;
        last_known = 0; last_pa = '0;
        for (int n = 0; n < 300; n++) begin
            req = ($urandom_range(0, 3) != 0);
            wr  = ($urandom_range(0, 3) == 0);
            cp0_entryhi = {19'($urandom_range(0, 3)), 8'($urandom_range(0, 2))};
            widx = 4'($urandom_range(0, 15));
            cp0_index = widx;
            cp0_lo0 = 26'($urandom);
            cp0_lo1 = 26'($urandom);
            if ($urandom_range(0, 7) == 0) lk_vaddr = {2'b10, 30'($urandom)};
            else lk_vaddr = {19'($urandom_range(0, 3)), 13'($urandom)};
            lk_store = 1'($urandom);
            lk_req = req; tlbwi_req = wr;
            model_lookup(lk_vaddr, lk_store, cp0_entryhi[7:0], ep, er, ei, em);
            step();
            if (wr) begin
                m_hi[widx] = cp0_entryhi; m_lo0[widx] = cp0_lo0; m_lo1[widx] = cp0_lo1;
            end
            checks++;
            if (req) begin
                if (lk_done !== 1 || {lk_refill, lk_invalid, lk_modified} !== {er, ei, em}
                    || (!er && lk_paddr !== ep)) begin
                    failures++;
                    $display("[TB] FAIL b2b_lookup n=%0d va=%h: got done=%b pa=%h flags=%b%b%b, want 1 %h %b%b%b",
                             n, lk_vaddr, lk_done, lk_paddr, lk_refill, lk_invalid, lk_modified, ep, er, ei, em);
                end
                last_known = !er; last_pa = ep;
            end else if (lk_done !== 0 || (last_known && lk_paddr !== last_pa)) begin
                failures++;
                $display("[TB] FAIL b2b_idle n=%0d: got done=%b pa=%h, want 0 %h", n, lk_done, lk_paddr, last_pa);
            end
        end
        idle_inputs();
        for (int n = 0; n < 60; n++) begin
            int hit;
            logic [3:0] ri;
            logic g;
            cp0_entryhi = {19'($urandom_range(0, 3)), 8'($urandom_range(0, 2))};
            ri = 4'($urandom_range(0, 15));
            cp0_index = ri;
            if (n % 2 == 0) begin
                hit = model_match(cp0_entryhi[26:8], cp0_entryhi[7:0]);
                tlbp_req = 1;
                step();
                tlbp_req = 0;
                checks++;
                if (probe_done !== 1 || probe_found !== (hit >= 0) || (hit >= 0 && probe_index !== 4'(hit))
                    || (hit < 0 && probe_index !== 4'd0)) begin
                    failures++;
                    $display("[TB] FAIL rand_probe key=%h: got done=%b found=%b idx=%0d, want hit=%0d",
                             cp0_entryhi, probe_done, probe_found, probe_index, hit);
                end
            end else begin
                g = m_lo0[ri][0] & m_lo1[ri][0];
                tlbr_req = 1;
                step();
                tlbr_req = 0;
                checks++;
                if (rd_done !== 1 || rd_entryhi !== m_hi[ri] || rd_lo0 !== {m_lo0[ri][25:1], g}
                    || rd_lo1 !== {m_lo1[ri][25:1], g}) begin
                    failures++;
                    $display("[TB] FAIL rand_read idx=%0d: got hi=%h lo0=%h lo1=%h, want %h %h %h",
                             ri, rd_entryhi, rd_lo0, rd_lo1, m_hi[ri], {m_lo0[ri][25:1], g}, {m_lo1[ri][25:1], g});
                end
            end
        end
    endtask

    task automatic test_reset_inflight();
        write_entry(4'd4, {19'h00400, 8'h05}, mk_lo(20'h00777, 1, 1, 1), mk_lo(20'h00888, 1, 1, 1));
        cp0_entryhi = {19'h00400, 8'h05};
        lk_req = 1; lk_vaddr = 32'h00800ABC; tlbp_req = 1;
        #3;
        rst = 0;
        #1;
        checks++;
        if ({probe_done, lk_done, lk_paddr, probe_found} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_async: got pd=%b lk=%b pa=%h found=%b, want all zero",
                     probe_done, lk_done, lk_paddr, probe_found);
        end
        idle_inputs();
        step();
        rst = 1;
        model_clear();
        step();
        checks++;
        if (probe_done !== 0 || lk_done !== 0) begin
            failures++;
            $display("[TB] FAIL reset_discard: got probe_done=%b lk_done=%b, want 0 0", probe_done, lk_done);
        end
        lookup(32'h00800ABC, 0);
        checks++;
        if (lk_done !== 1 || {lk_refill, lk_invalid, lk_modified} !== 3'b100) begin
            failures++;
            $display("[TB] FAIL reset_cleared_entries: got done=%b flags=%b%b%b, want 1 100",
                     lk_done, lk_refill, lk_invalid, lk_modified);
        end
    endtask

    // Scenarios run in order; each one builds on the model state left by the last.
    initial begin
        test_reset();
        test_translate();
        test_probe_read();
        test_priority();
        test_bypass_same_cycle();
        test_back_to_back();
        test_reset_inflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
